// File: rtl/gshare_bp.sv
// gshare_bp: global-history branch predictor.
// A table of saturating counters is indexed by the fetch tag, optionally XORed
// with a speculative global history register (GHR). After reset an init sweep
// writes INIT_VAL into every entry, one per enabled cycle, so the table has no
// reset and can map onto a RAM. The ROB trains counters at commit and repairs
// the GHR on a mispredict.
module gshare_bp #(
  parameter int              IDX_W    = 8,
  parameter int              CNT_W    = 2,
  parameter int              HIST_W   = 8,
  parameter bit              GSHARE   = 1'b1,
  parameter logic [CNT_W-1:0] INIT_VAL = {CNT_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              in_fetcher_valid,
  input  logic [IDX_W-1:0]  in_fetcher_tag,
  output logic              out_fetcher_jump_res,
  output logic [HIST_W-1:0] out_fetcher_hist,
  output logic              out_bp_ready,
  input  logic              in_rob_bp_res,
  input  logic [IDX_W-1:0]  in_rob_tag,
  input  logic [HIST_W-1:0] in_rob_hist,
  input  logic              in_rob_jump_res,
  input  logic              in_rob_mispredict
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       init_idx;
  logic                   bp_ready;
  logic [HIST_W-1:0]      ghr;
  logic [CNT_W-1:0]       table_q [DEPTH];

  logic [IDX_W-1:0]       fetch_idx;
  logic [IDX_W-1:0]       train_idx;
  logic [CNT_W-1:0]       train_old;
  logic [CNT_W-1:0]       train_new;
  logic                   pred_run;

  // Table index: tag, optionally hashed with the zero-extended history.
  function automatic logic [IDX_W-1:0] bp_hash(input logic [IDX_W-1:0]  tag,
                                               input logic [HIST_W-1:0] h);
    logic [IDX_W-1:0] hx;
    hx = IDX_W'(h);
    return GSHARE ? (tag ^ hx) : tag;
  endfunction

  // Counter step up, holding at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Counter step down, holding at zero.
  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  // Shift one outcome bit into a history value; the oldest bit falls off.
  // The truncating cast keeps this valid for HIST_W = 1.
  function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h,
                                                    input logic              b);
    return HIST_W'({h, b});
  endfunction

  assign fetch_idx = bp_hash(in_fetcher_tag, ghr);
  assign train_idx = bp_hash(in_rob_tag, in_rob_hist);
  assign train_old = table_q[train_idx];
  assign train_new = in_rob_jump_res ? sat_inc(train_old) : sat_dec(train_old);
  assign pred_run  = table_q[fetch_idx][CNT_W-1];

  // Until the sweep finishes the table holds garbage, so report the init value.
  assign out_fetcher_jump_res = (state == ST_RUN) ? pred_run : INIT_VAL[CNT_W-1];
  assign out_fetcher_hist     = ghr;
  assign out_bp_ready         = bp_ready;

  // Init-sweep FSM: walk every index once, then run; ready is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_idx <= '0;
      bp_ready <= 1'b0;
    end else if (rdy) begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + IDX_W'(1);
          if (init_idx == {IDX_W{1'b1}}) begin
            state    <= ST_RUN;
            bp_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          state    <= ST_RUN;
          bp_ready <= 1'b1;
        end
        default: begin
          state    <= ST_INIT;
          init_idx <= '0;
          bp_ready <= 1'b0;
        end
      endcase
    end
  end

  // Speculative history: mispredict repair wins over the fetch shift, since a
  // fetch in the same cycle is on the squashed path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (rdy && (state == ST_RUN)) begin
      if (in_rob_mispredict && in_rob_bp_res) begin
        ghr <= hist_shift(in_rob_hist, in_rob_jump_res);
      end else if (in_fetcher_valid) begin
        ghr <= hist_shift(ghr, pred_run);
      end
    end
  end

  // Counter table: single write port shared by the init sweep and training.
  // A same-cycle fetch of the trained entry reads the pre-write value.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (state == ST_INIT) begin
        table_q[init_idx] <= INIT_VAL;
      end else if (in_rob_bp_res) begin
        table_q[train_idx] <= train_new;
      end
    end
  end

endmodule

// File: doc/gshare_bp.md
# gshare_bp

Parametrised global-history branch predictor: a table of saturating counters indexed by the fetch tag, optionally XOR-hashed with a speculative global history register (GHR). It sits between the fetcher (prediction lookup) and the ROB (commit-time training and mispredict history repair). After reset, a sweep FSM initialises the table, so the table can map to RAM. It is the generalised successor of the fixed 256-entry 2-bit bimodal predictor.

## Interface
- IDX_W, 8, table index width; table depth = 2^IDX_W
- CNT_W, 2, counter width (>=2)
- HIST_W, 8, GHR width (1..IDX_W)
- GSHARE, 1, 1 = index is tag XOR zero-extended history; 0 = index is tag (bimodal)
- INIT_VAL, {CNT_W{1'b1}}, counter value written by the init sweep

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; all state frozen when low
- in_fetcher_valid  in  1  lookup performed this cycle (advances GHR)
- in_fetcher_tag  in  IDX_W  fetch PC-derived tag
- out_fetcher_jump_res  out  1  predicted taken
- out_fetcher_hist  out  HIST_W  current GHR, carried with the instruction to the ROB
- out_bp_ready  out  1  init complete; predictions valid
- in_rob_bp_res  in  1  committed branch trains the table
- in_rob_tag  in  IDX_W  tag of the committed branch
- in_rob_hist  in  HIST_W  GHR snapshot captured at its prediction
- in_rob_jump_res  in  1  actual outcome
- in_rob_mispredict  in  1  prediction was wrong; repair GHR

## Operation
- Index: idx(tag,h) = GSHARE ? tag ^ {0,h} : tag. Fetch uses (in_fetcher_tag, GHR); training uses (in_rob_tag, in_rob_hist).
- FSM states INIT and RUN. Reset enters INIT with init_idx=0 and GHR=0.
- INIT: each rdy cycle writes INIT_VAL to table[init_idx] and increments init_idx. The write at init_idx = 2^IDX_W-1 moves the FSM to RUN. Fetch and ROB inputs are ignored. The GHR holds 0. out_fetcher_jump_res is forced to INIT_VAL[CNT_W-1].
- RUN: out_fetcher_jump_res = table[idx][CNT_W-1], read combinationally.
- Training when rdy & in_rob_bp_res: a taken outcome increments the counter, saturating at all-ones. A not-taken outcome decrements it, saturating at 0. Arithmetic is CNT_W bits wide and never wraps.
- GHR update when rdy, in priority order:
  - in_rob_mispredict & in_rob_bp_res: GHR <= {in_rob_hist[HIST_W-2:0], in_rob_jump_res}. For HIST_W=1, GHR <= in_rob_jump_res.
  - otherwise in_fetcher_valid: GHR <= {GHR[HIST_W-2:0], out_fetcher_jump_res}.
  - otherwise GHR is held.
- A simultaneous fetch and mispredict drops the fetch shift, because the fetched instruction is on the squashed path.
- Fetch and training may address the same entry in one cycle. The fetch sees the old value; the write lands.

## Timing
- Reset values, immediate on rst_n low: out_bp_ready=0, out_fetcher_hist=0, out_fetcher_jump_res=INIT_VAL[CNT_W-1], FSM=INIT, init_idx=0.
- rst_n asserted mid-operation, including mid-INIT, restarts the sweep from index 0. Table contents are don't-care until the sweep completes.
- out_bp_ready rises at the clock edge that completes 2^IDX_W rdy-high INIT cycles. It never falls except on reset.
- Prediction latency is 0 cycles (combinational from tag and GHR). Training and GHR updates are visible the cycle after the edge.
- rdy low: init_idx, FSM, GHR and table are frozen. Outputs keep reflecting the current state.

## Test plan
- Reset release with rdy=1 (defaults) -> out_bp_ready=0 for exactly 256 cycles, then 1. Every tag then predicts 1. rdy toggled low for 10 cycles during INIT -> ready is delayed by exactly 10 cycles.
- GSHARE=0, tag 5: four not-taken commits -> counter 11,10,01,00,00, prediction flips to 0 after the second commit. Then two taken commits -> 10, prediction 1.
- GSHARE=1, GHR=0, all entries 11: three fetches with in_fetcher_valid=1 -> out_fetcher_hist 0x00 -> 0x01 -> 0x03 -> 0x07.
- GHR=0x07, same cycle mispredict (in_rob_hist=0x12, jump_res=0) plus fetch valid -> GHR=0x24 next cycle, fetch shift discarded.
- GSHARE=1, tag 0x0F with GHR 0x03 and commit tag 0x0C with hist 0x00 (both index 0x0C, counter 11), commit not-taken -> same-cycle prediction 1, following cycle counter 10, prediction still 1.
- rst_n pulsed low asynchronously (between edges) at init_idx=100 -> out_bp_ready=0 and GHR=0 immediately. The sweep restarts and out_bp_ready rises 256 rdy cycles after release.
